// File: rtl/tof_pkg.sv
// Shared types and default constants for the ToF tank-measurement pipeline.
package tof_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        MUL   = 2'd2,
        OUT   = 2'd3
    } vol_state_t;

    localparam int unsigned N_PLANES_DEF = 8;
    localparam int unsigned SURF_W_DEF   = 32;
    localparam int unsigned VOL_W_DEF    = 48;
    localparam logic [15:0] DZ_DEF       = 16'd10;

endpackage : tof_pkg

// File: rtl/sat_add.sv
// Unsigned saturating adder: clamps to all ones on carry-out and flags it.
module sat_add #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

    logic [W:0] raw;

    // Full-width add, then clamp when the carry bit is set.
    always_comb begin
        raw   = {1'b0, a_i} + {1'b0, b_i};
        ovf_o = raw[W];
        sum_o = raw[W] ? '1 : raw[W-1:0];
    end

endmodule : sat_add

// File: rtl/plane_vol_accum.sv
// Frame volume accumulator: sums N_PLANES surface values, scales the total
// by the plane spacing DZ and hands the volume out over valid/ready.
module plane_vol_accum
    import tof_pkg::*;
#(
    parameter int unsigned SURF_W   = SURF_W_DEF,
    parameter int unsigned N_PLANES = N_PLANES_DEF,
    parameter logic [15:0] DZ       = DZ_DEF,
    parameter int unsigned VOL_W    = VOL_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        surf_vld,
    input  logic [SURF_W-1:0]           surf,
    output logic                        surf_ack,
    output logic [VOL_W-1:0]            vol,
    output logic                        vol_vld,
    input  logic                        vol_rdy,
    output logic [$clog2(N_PLANES)-1:0] plane_idx,
    output logic                        busy,
    output logic                        ovf
);

    localparam int unsigned IDX_W = $clog2(N_PLANES);
    localparam int unsigned PRD_W = VOL_W + 16;

    vol_state_t       state_q;
    logic [VOL_W-1:0] acc_q;
    logic [VOL_W-1:0] vol_q;
    logic [IDX_W-1:0] idx_q;
    logic             ack_q;
    logic             vol_vld_q;
    logic             ovf_q;

    logic [VOL_W-1:0] surf_ext;
    logic [VOL_W-1:0] acc_d;
    logic             add_ovf;
    logic [PRD_W-1:0] prod;
    logic             mul_ovf;
    logic [VOL_W-1:0] vol_d;
    logic             last_plane;

    // Zero-extend the incoming surface to accumulator width.
    always_comb begin
        surf_ext = VOL_W'(surf);
    end

    sat_add #(
        .W(VOL_W)
    ) u_acc_add (
        .a_i  (acc_q),
        .b_i  (surf_ext),
        .sum_o(acc_d),
        .ovf_o(add_ovf)
    );

    // Full-width scale by DZ; any bit above VOL_W forces saturation.
    always_comb begin
        prod    = PRD_W'(acc_q) * PRD_W'(DZ);
        mul_ovf = |prod[PRD_W-1 -: 16];
        vol_d   = mul_ovf ? '1 : prod[VOL_W-1:0];
    end

    // The plane counter is IDX_W wide, so for a power-of-two N_PLANES it
    // reads 0 again once the final plane of the frame has been accepted.
    always_comb begin
        last_plane = (idx_q == IDX_W'(N_PLANES - 1));
    end

    // Frame FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            vol_q     <= '0;
            idx_q     <= '0;
            ack_q     <= 1'b0;
            vol_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ACCUM;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (start) begin
                        acc_q <= '0;
                        idx_q <= '0;
                        ovf_q <= 1'b0;
                    end else if (surf_vld) begin
                        acc_q <= acc_d;
                        ovf_q <= ovf_q | add_ovf;
                        idx_q <= idx_q + 1'b1;
                        ack_q <= 1'b1;
                        if (last_plane) begin
                            state_q <= MUL;
                        end
                    end
                end
                MUL: begin
                    vol_q     <= vol_d;
                    ovf_q     <= ovf_q | mul_ovf;
                    vol_vld_q <= 1'b1;
                    state_q   <= OUT;
                end
                OUT: begin
                    if (vol_rdy) begin
                        vol_vld_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Output drive from registered state.
    always_comb begin
        surf_ack  = ack_q;
        vol       = vol_q;
        vol_vld   = vol_vld_q;
        plane_idx = idx_q;
        busy      = (state_q != IDLE);
        ovf       = ovf_q;
    end

endmodule : plane_vol_accum

// File: tb/tb_plane_vol_accum.sv
// Directed bench for plane_vol_accum: three instances (48/34/33-bit volume)
// share one stimulus stream so saturation in both the add and the multiply
// can be observed.
module tb_plane_vol_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        surf_vld = 1'b0;
    logic        vol_rdy = 1'b0;
    logic [31:0] surf = '0;

    logic        ack_a, vld_a, busy_a, ovf_a;
    logic [47:0] vol_a;
    logic [1:0]  idx_a;
    logic        ack_b, vld_b, busy_b, ovf_b;
    logic [33:0] vol_b;
    logic [1:0]  idx_b;
    logic        ack_c, vld_c, busy_c, ovf_c;
    logic [32:0] vol_c;
    logic [1:0]  idx_c;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0][31:0] s;
        logic [63:0]      v48;
        logic             o48;
        logic [63:0]      v34;
        logic             o34;
        logic [63:0]      v33;
        logic             o33;
    } vec_t;

    vec_t tbl[6];

    always #5 clk = ~clk;

    plane_vol_accum #(.SURF_W(32), .N_PLANES(4), .DZ(16'd10), .VOL_W(48)) dut_a (
        .clk(clk), .rst(rst), .start(start), .surf_vld(surf_vld), .surf(surf),
        .surf_ack(ack_a), .vol(vol_a), .vol_vld(vld_a), .vol_rdy(vol_rdy),
        .plane_idx(idx_a), .busy(busy_a), .ovf(ovf_a));

    plane_vol_accum #(.SURF_W(32), .N_PLANES(4), .DZ(16'd10), .VOL_W(34)) dut_b (
        .clk(clk), .rst(rst), .start(start), .surf_vld(surf_vld), .surf(surf),
        .surf_ack(ack_b), .vol(vol_b), .vol_vld(vld_b), .vol_rdy(vol_rdy),
        .plane_idx(idx_b), .busy(busy_b), .ovf(ovf_b));

    plane_vol_accum #(.SURF_W(32), .N_PLANES(4), .DZ(16'd1), .VOL_W(33)) dut_c (
        .clk(clk), .rst(rst), .start(start), .surf_vld(surf_vld), .surf(surf),
        .surf_ack(ack_c), .vol(vol_c), .vol_vld(vld_c), .vol_rdy(vol_rdy),
        .plane_idx(idx_c), .busy(busy_c), .ovf(ovf_c));

    function automatic vec_t mk(input logic [31:0] s0, input logic [31:0] s1,
                                input logic [31:0] s2, input logic [31:0] s3,
                                input logic [63:0] v48, input logic o48,
                                input logic [63:0] v34, input logic o34,
                                input logic [63:0] v33, input logic o33);
        vec_t r;
        r.s   = {s3, s2, s1, s0};
        r.v48 = v48; r.o48 = o48;
        r.v34 = v34; r.o34 = o34;
        r.v33 = v33; r.o33 = o33;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 64'(busy_a), 64'd1);
        chk("start_idx", 64'(idx_a), 64'd0);
        chk("start_ovf", 64'(ovf_a), 64'd0);
    endtask

    // One surface pulse; non-final planes leave two idle cycles afterwards.
    task automatic send(input logic [31:0] v, input logic [1:0] exp_idx, input bit last);
        surf     = v;
        surf_vld = 1'b1;
        tick();
        surf_vld = 1'b0;
        chk("ack_pulse", 64'(ack_a), 64'd1);
        chk("ack_pulse_b", 64'(ack_b), 64'd1);
        chk("plane_idx", 64'(idx_a), 64'(exp_idx));
        if (!last) begin
            tick();
            chk("ack_width", 64'(ack_a), 64'd0);
            tick();
        end
    endtask

    // Called in the MUL cycle (one cycle after the last surface was sampled).
    task automatic finish(input vec_t e, input int hold, input bit poke);
        chk("mul_vld", 64'(vld_a), 64'd0);
        chk("mul_busy", 64'(busy_a), 64'd1);
        if (poke) begin
            surf     = 32'd999;
            surf_vld = 1'b1;
        end
        tick();
        surf_vld = 1'b0;
        chk("out_vld_a", 64'(vld_a), 64'd1);
        chk("out_vld_b", 64'(vld_b), 64'd1);
        chk("out_vld_c", 64'(vld_c), 64'd1);
        chk("vol_a", 64'(vol_a), e.v48);
        chk("ovf_a", 64'(ovf_a), 64'(e.o48));
        chk("vol_b", 64'(vol_b), e.v34);
        chk("ovf_b", 64'(ovf_b), 64'(e.o34));
        chk("vol_c", 64'(vol_c), e.v33);
        chk("ovf_c", 64'(ovf_c), 64'(e.o33));
        if (poke) begin
            chk("mul_poke_ack", 64'(ack_a), 64'd0);
            chk("mul_poke_idx", 64'(idx_a), 64'd0);
        end
        for (int i = 0; i < hold; i++) begin
            if (poke && i == 0) begin
                surf     = 32'd777;
                surf_vld = 1'b1;
            end
            tick();
            surf_vld = 1'b0;
            chk("hold_vld", 64'(vld_a), 64'd1);
            chk("hold_vol", 64'(vol_a), e.v48);
            chk("hold_busy", 64'(busy_a), 64'd1);
            if (poke && i == 0) begin
                chk("out_poke_ack", 64'(ack_a), 64'd0);
                chk("out_poke_idx", 64'(idx_a), 64'd0);
            end
        end
        vol_rdy = 1'b1;
        tick();
        vol_rdy = 1'b0;
        chk("hs_vld", 64'(vld_a), 64'd0);
        chk("hs_busy", 64'(busy_a), 64'd0);
        chk("hs_vol_kept", 64'(vol_a), e.v48);
    endtask

    initial begin
        vec_t r;

        tbl[0] = mk(32'd100, 32'd200, 32'd300, 32'd400,
                    64'd10000, 1'b0, 64'd10000, 1'b0, 64'd1000, 1'b0);
        tbl[1] = mk(32'd0, 32'd0, 32'd0, 32'd0,
                    64'd0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
        tbl[2] = mk(32'd1, 32'd2, 32'd3, 32'd4,
                    64'd100, 1'b0, 64'd100, 1'b0, 64'd10, 1'b0);
        tbl[3] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    64'd171798691800, 1'b0, 64'd17179869183, 1'b1, 64'd8589934591, 1'b1);
        tbl[4] = mk(32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0,
                    64'd42949672960, 1'b0, 64'd17179869183, 1'b1, 64'd4294967296, 1'b0);
        tbl[5] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,
                    64'd128849018860, 1'b0, 64'd17179869183, 1'b1, 64'd8589934591, 1'b1);

        // Reset state
        #3;
        chk("rst_ack", 64'(ack_a), 64'd0);
        chk("rst_vol", 64'(vol_a), 64'd0);
        chk("rst_vld", 64'(vld_a), 64'd0);
        chk("rst_idx", 64'(idx_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_ovf", 64'(ovf_a), 64'd0);
        #5 rst = 1'b1;
        tick();

        // surf_vld in IDLE is ignored
        surf     = 32'd5;
        surf_vld = 1'b1;
        tick();
        surf_vld = 1'b0;
        tick();
        chk("idle_ack", 64'(ack_a), 64'd0);
        chk("idle_busy", 64'(busy_a), 64'd0);
        chk("idle_idx", 64'(idx_a), 64'd0);

        // Table-driven frames; the first one also exercises backpressure
        // and surf_vld pokes in MUL and OUT.
        for (int k = 0; k < 6; k++) begin
            r = tbl[k];
            do_start();
            for (int p = 0; p < 4; p++) begin
                send(r.s[p], 2'((p + 1) % 4), (p == 3));
            end
            finish(r, (k == 0) ? 5 : 0, (k == 0));
        end

        // surf_vld in IDLE after a frame leaves vol and plane_idx alone
        surf     = 32'd123;
        surf_vld = 1'b1;
        tick();
        surf_vld = 1'b0;
        chk("idle2_ack", 64'(ack_a), 64'd0);
        chk("idle2_vol", 64'(vol_a), tbl[5].v48);
        chk("idle2_idx", 64'(idx_a), 64'd0);

        // Restart mid-frame, start coincident with surf_vld
        do_start();
        send(32'd50, 2'd1, 1'b0);
        send(32'd50, 2'd2, 1'b0);
        start    = 1'b1;
        surf     = 32'd77;
        surf_vld = 1'b1;
        tick();
        start    = 1'b0;
        surf_vld = 1'b0;
        chk("restart_ack", 64'(ack_a), 64'd0);
        chk("restart_idx", 64'(idx_a), 64'd0);
        chk("restart_busy", 64'(busy_a), 64'd1);
        tick();
        send(32'd1, 2'd1, 1'b0);
        send(32'd1, 2'd2, 1'b0);
        send(32'd1, 2'd3, 1'b0);
        send(32'd1, 2'd0, 1'b1);
        r = mk(32'd1, 32'd1, 32'd1, 32'd1,
               64'd40, 1'b0, 64'd40, 1'b0, 64'd4, 1'b0);
        finish(r, 0, 1'b0);

        // Asynchronous reset mid-ACCUM
        do_start();
        send(32'd50, 2'd1, 1'b0);
        send(32'd50, 2'd2, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("arst_ack", 64'(ack_a), 64'd0);
        chk("arst_vol", 64'(vol_a), 64'd0);
        chk("arst_vld", 64'(vld_a), 64'd0);
        chk("arst_idx", 64'(idx_a), 64'd0);
        chk("arst_busy", 64'(busy_a), 64'd0);
        chk("arst_ovf", 64'(ovf_a), 64'd0);
        tick();
        #3 rst = 1'b1;
        tick();
        for (int j = 0; j < 2; j++) begin
            surf     = 32'd9;
            surf_vld = 1'b1;
            tick();
            surf_vld = 1'b0;
            chk("post_rst_ack", 64'(ack_a), 64'd0);
            chk("post_rst_busy", 64'(busy_a), 64'd0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_plane_vol_accum
